// File: rtl/ifu_fetch_pkg.sv
// ============================================================================
// ifu_fetch_pkg : shared constants, FSM states and fault codes for ifu_fetch
// Revision      : 1.0
// ============================================================================
`default_nettype none

package ifu_fetch_pkg;

  localparam int          IFU_XLEN       = 64;
  localparam logic [63:0] IFU_START_ADDR = 64'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [1:0] IF_FAULT_NONE     = 2'b00;
  localparam logic [1:0] IF_FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] IF_FAULT_ACCESS   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/ifu_fetch_reg.sv
// ============================================================================
// ifu_fetch_reg : generic register with write enable and sync reset value
// Revision      : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= RST_VAL;
    else if (wen) q <= d;
  end

endmodule

`default_nettype wire

// File: rtl/ifu_fetch.sv
// ============================================================================
// ifu_fetch : instruction fetch stage, one outstanding request, 1-entry buffer
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int             XLEN       = IFU_XLEN,
  parameter logic [XLEN-1:0] START_ADDR = IFU_START_ADDR[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  output logic            pc_adv,
  input  logic            flush,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [31:0]     mem_resp_data,
  input  logic            mem_resp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic [1:0]      inst_fault
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic            w_misalign;
  logic            w_accept;
  logic            w_buf_wen;
  logic [31:0]     w_buf_inst;
  logic [1:0]      w_buf_fault;
  logic            w_outstanding;

  assign w_misalign    = (pc[1:0] != 2'b00);
  assign mem_req_valid = !rst && (r_state == S_REQ) && !w_misalign;
  assign mem_req_addr  = pc;
  assign w_accept      = mem_req_valid && mem_req_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_REQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    pc_adv        = 1'b0;
    inst_valid    = 1'b0;
    w_buf_wen     = 1'b0;
    w_buf_inst    = 32'h0;
    w_buf_fault   = IF_FAULT_NONE;
    w_outstanding = 1'b0;

    case (r_state)
      S_REQ: begin
        if (w_misalign) begin
          w_buf_wen   = 1'b1;
          w_buf_fault = IF_FAULT_MISALIGN;
          w_state_nxt = S_HOLD;
        end else if (w_accept) begin
          w_state_nxt = S_WAIT;
        end
        w_outstanding = w_accept;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_buf_wen   = 1'b1;
          w_buf_inst  = mem_resp_err ? 32'h0 : mem_resp_data;
          w_buf_fault = mem_resp_err ? IF_FAULT_ACCESS : IF_FAULT_NONE;
          w_state_nxt = S_HOLD;
        end
        w_outstanding = !mem_resp_valid;
      end
      S_HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          pc_adv      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (mem_resp_valid) w_state_nxt = S_REQ;
        w_outstanding = !mem_resp_valid;
      end
      default: w_state_nxt = S_REQ;
    endcase

    // A redirect wins over everything; a response landing in the same cycle
    // retires the outstanding request, so there is nothing left to drain.
    if (flush) begin
      pc_adv      = 1'b1;
      inst_valid  = 1'b0;
      w_buf_wen   = 1'b0;
      w_state_nxt = w_outstanding ? S_DRAIN : S_REQ;
    end

    if (rst) begin
      pc_adv     = 1'b0;
      inst_valid = 1'b0;
    end
  end

  ifu_fetch_reg #(.WIDTH(32), .RST_VAL(32'h0)) u_buf_inst (
    .clk(clk), .rst(rst), .wen(w_buf_wen), .d(w_buf_inst), .q(inst)
  );

  ifu_fetch_reg #(.WIDTH(XLEN), .RST_VAL(START_ADDR)) u_buf_pc (
    .clk(clk), .rst(rst), .wen(w_buf_wen), .d(pc), .q(inst_pc)
  );

  ifu_fetch_reg #(.WIDTH(2), .RST_VAL(IF_FAULT_NONE)) u_buf_fault (
    .clk(clk), .rst(rst), .wen(w_buf_wen), .d(w_buf_fault), .q(inst_fault)
  );

  a_no_stray_resp : assert property (@(posedge clk) disable iff (rst)
    !(mem_resp_valid && ((r_state == S_REQ) || (r_state == S_HOLD))));

endmodule

`default_nettype wire
